// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch stage: reset PC, nop encoding,
// next-PC select codes and the branch offset helper.
package mips_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   // Source of the next PC, in increasing redirect priority.
   typedef enum logic [1:0] {
      SEQ = 2'd0,
      BR  = 2'd1,
      J   = 2'd2,
      JR  = 2'd3
   } npc_sel_t;

   // Branch displacement in bytes: sign-extended word offset.
   function automatic logic [31:0] br_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC calculation: priority select between sequential fetch and the
// three redirect kinds, plus their target arithmetic. Purely combinational;
// redirects only count when the IF/ID instruction is valid.
module npc_calc
   import mips_fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] if_pc_plus4,
   input  logic        if_valid,
   input  logic        br_taken,
   input  logic [15:0] br_imm16,
   input  logic        j_en,
   input  logic [25:0] j_index26,
   input  logic        jr_en,
   input  logic [31:0] jr_target,
   output logic [31:0] npc,
   output logic [1:0]  sel
);

   npc_sel_t w_sel;

   // Pick the highest-priority redirect; a bubble in IF/ID cannot redirect.
   always_comb begin
      w_sel = SEQ;
      if (if_valid && jr_en) begin
         w_sel = JR;
      end else if (if_valid && j_en) begin
         w_sel = J;
      end else if (if_valid && br_taken) begin
         w_sel = BR;
      end else begin
         w_sel = SEQ;
      end
   end

   // Form the target for the selected source; all sums wrap at 32 bits.
   always_comb begin
      npc = pc + 32'd4;
      case (w_sel)
         SEQ:     npc = pc + 32'd4;
         BR:      npc = if_pc_plus4 + br_offset(br_imm16);
         J:       npc = {if_pc_plus4[31:28], j_index26, 2'b00};
         JR:      npc = jr_target;
         default: npc = pc + 32'd4;
      endcase
   end

   assign sel = w_sel;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, addresses the instruction memory and captures
// the returned word into the IF/ID register. Redirects beat stalls, and a
// redirect flushes the wrong-path fetch, leaving one bubble.
// Optional build macro PC_BOUNDS_CHECK_EN: a next PC outside the populated
// IM window (or misaligned) freezes the stage and raises sticky fetch_fault.
module pc_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          IM_AW    = 10,
   parameter int          IM_DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [IM_AW-1:0] im_addr,
   input  logic [31:0]      im_dout,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [15:0]      br_imm16,
   input  logic             j_en,
   input  logic [25:0]      j_index26,
   input  logic             jr_en,
   input  logic [31:0]      jr_target,
   output logic [31:0]      pc,
   output logic [31:0]      if_instr,
   output logic [31:0]      if_pc,
   output logic [31:0]      if_pc_plus4,
   output logic             if_valid,
   output logic             fetch_fault
);

   logic [31:0] r_pc;
   logic [31:0] r_if_instr;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_pc_plus4;
   logic        r_if_valid;

   logic [31:0] w_npc;
   logic [1:0]  w_sel;
   logic        w_redirect;
   logic [31:0] w_offset;

   npc_calc u_npc_calc (
      .pc          (r_pc),
      .if_pc_plus4 (r_if_pc_plus4),
      .if_valid    (r_if_valid),
      .br_taken    (br_taken),
      .br_imm16    (br_imm16),
      .j_en        (j_en),
      .j_index26   (j_index26),
      .jr_en       (jr_en),
      .jr_target   (jr_target),
      .npc         (w_npc),
      .sel         (w_sel)
   );

   assign w_redirect = (w_sel != SEQ);

   // IM word index relative to the reset PC; upper bits simply drop off.
   assign w_offset = r_pc - RESET_PC;
   assign im_addr  = IM_AW'(w_offset >> 2);

`ifdef PC_BOUNDS_CHECK_EN
   localparam logic [31:0] LAST_PC = RESET_PC + (32'(IM_DEPTH) * 32'd4) - 32'd4;

   logic r_fetch_fault;
   logic w_advance;
   logic w_oob;

   // A PC update happens on any redirect or on an unstalled sequential step.
   assign w_advance = w_redirect || !stall;
   assign w_oob     = (w_npc < RESET_PC) || (w_npc > LAST_PC) || (w_npc[1:0] != 2'b00);
`else
   logic w_unused_depth;
   assign w_unused_depth = (IM_DEPTH == 0);
`endif

   // PC and IF/ID pipeline register: reset, (fault freeze), redirect, stall, advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_if_instr    <= NOP_INSTR;
         r_if_pc       <= 32'h0000_0000;
         r_if_pc_plus4 <= 32'h0000_0000;
         r_if_valid    <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
         r_fetch_fault <= 1'b0;
      end else if (r_fetch_fault) begin
         r_if_valid    <= 1'b0;
      end else if (w_advance && w_oob) begin
         r_if_valid    <= 1'b0;
         r_fetch_fault <= 1'b1;
`endif
      end else if (w_redirect) begin
         r_pc          <= w_npc;
         r_if_instr    <= NOP_INSTR;
         r_if_valid    <= 1'b0;
      end else if (!stall) begin
         r_pc          <= w_npc;
         r_if_instr    <= im_dout;
         r_if_pc       <= r_pc;
         r_if_pc_plus4 <= r_pc + 32'd4;
         r_if_valid    <= 1'b1;
      end else begin
         r_pc          <= r_pc;
         r_if_instr    <= r_if_instr;
         r_if_pc       <= r_if_pc;
         r_if_pc_plus4 <= r_if_pc_plus4;
         r_if_valid    <= r_if_valid;
      end
   end

   assign pc          = r_pc;
   assign if_instr    = r_if_instr;
   assign if_pc       = r_if_pc;
   assign if_pc_plus4 = r_if_pc_plus4;
   assign if_valid    = r_if_valid;
`ifdef PC_BOUNDS_CHECK_EN
   assign fetch_fault = r_fetch_fault;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule
